gesummv_host: RTL
=================

GESUMMV_HOST -- requirements
Module: gesummv_host

Interface
REQ-001 Parameter N, default 8, sets the vector length and matrix dimension, N = 2^LOGN.
REQ-002 Parameter LOGN, default 3, sets the index width.
REQ-003 Parameter DW, default 32, sets the data word width.
REQ-004 Parameter TIMEOUT, default 4096, sets the maximum cycles allowed in RUN.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 load_valid  in  1  host load word valid.
REQ-008 load_ready  out  1  load accepted this cycle when load_valid is also high.
REQ-009 load_sel  in  2  target array: 0=A, 1=B, 2=x, 3=discard.
REQ-010 load_addr  in  2*LOGN  word address; x uses the low LOGN bits.
REQ-011 load_data  in  DW  word to load.
REQ-012 start  in  1  run request.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when the run completes.
REQ-015 err  out  1  sticky timeout flag.
REQ-016 tstart  out  1  kernel start pulse.
REQ-017 a_addr  in  2*LOGN, a_rd_en  in  1, a_rd_data  out  DW  kernel read port for A.
REQ-018 b_addr  in  2*LOGN, b_rd_en  in  1, b_rd_data  out  DW  kernel read port for B.
REQ-019 x_addr  in  LOGN, x_rd_en  in  1, x_rd_data  out  DW  kernel read port for x.
REQ-020 tmp_addr  in  LOGN, tmp_wr_en  in  1, tmp_wr_data  in  DW  kernel write port for tmp.
REQ-021 y_addr  in  LOGN, y_wr_en  in  1, y_wr_data  in  DW  kernel write port for y.
REQ-022 res_valid  out  1, res_ready  in  1, res_idx  out  LOGN, res_y  out  DW, res_tmp  out  DW  result stream.

Function
REQ-023 Storage SHALL be: A and B of N*N words each, x/tmp/y of N words each, plus an N-bit written bitmap for y.
REQ-024 The FSM SHALL have states IDLE, START, RUN, DRAIN, FIN.
REQ-025 IDLE: load_ready=1; a load handshake SHALL write load_data into the array selected by load_sel at load_addr; sel=3 SHALL accept and drop the word.
REQ-026 IDLE with start=1 SHALL go to START and clear the y bitmap; a load in the same cycle SHALL still be performed.
REQ-027 A start outside IDLE SHALL be ignored; load_ready=0 outside IDLE.
REQ-028 START: tstart SHALL be 1 for exactly this one cycle, clear the RUN cycle counter, then go to RUN.
REQ-029 Read ports: rd_en high at cycle t SHALL present the word at the address sampled at t on rd_data at t+1; rd_data SHALL hold its last value when rd_en is low; read ports are served in every state.
REQ-030 Write ports: tmp_wr_en or y_wr_en SHALL write the array in RUN only; writes in other states SHALL be ignored.
REQ-031 A y write SHALL set bitmap[y_addr]; a repeated address SHALL overwrite the data without error.
REQ-032 Simultaneous tmp and y writes in one cycle SHALL both commit.
REQ-033 RUN SHALL go to DRAIN on the cycle after the bitmap becomes all ones, so a final tmp write in the same cycle as the last y write is captured.
REQ-034 RUN with counter = TIMEOUT-1 and an incomplete bitmap SHALL set err and go to IDLE without a done pulse.
REQ-035 DRAIN: res_valid=1 with res_idx=i, res_y=y[i], res_tmp=tmp[i] for i = 0..N-1 in order.
REQ-036 DRAIN: i SHALL advance only on res_valid&res_ready; outputs SHALL be stable while res_ready=0.
REQ-037 The handshake at i=N-1 SHALL go to FIN.
REQ-038 FIN: done=1 for one cycle, then IDLE.
REQ-039 err SHALL clear only on rst or on a start accepted in IDLE.
REQ-040 Completion detection SHALL use the bitmap, not a write counter.

Reset
REQ-041 rst=1 SHALL force state IDLE, tstart=0, done=0, err=0, res_valid=0, busy=0, DRAIN index=0, bitmap=0, and all rd_data=0.
REQ-042 Array contents SHALL be retained across rst.
REQ-043 rst asserted mid-RUN or mid-DRAIN SHALL abort with no done pulse; the next start SHALL begin a fresh run.

Verification
REQ-044 Load A[9]=5 with sel=0, then a_rd_en=1, a_addr=9 at cycle t -> a_rd_data=5 at t+1 and held while a_rd_en=0.
REQ-045 Idle, start pulse -> tstart high exactly one cycle later, for exactly one cycle; busy=1 from that cycle.
REQ-046 RUN, y writes to addr 0..7 with tmp=i, y=10*i, res_ready=1 -> 8 results idx 0..7 with y=10*i, tmp=i, then one done pulse.
REQ-047 RUN, y writes to addr 3 twice (values 1 then 2) and the other 7 addresses once -> DRAIN entered after the 8th distinct address; res_y for idx 3 = 2.
REQ-048 TIMEOUT=16, no writes -> err=1 at cycle 16 of RUN, state IDLE, no done; next start clears err.
REQ-049 DRAIN with res_ready held low 5 cycles at idx 2 -> res_idx/res_y/res_tmp stable; rst then -> res_valid=0, busy=0 next cycle.

Source files
------------

// File: rtl/gesummv_host.sv
// Host-side buffer and sequencer for a GESUMMV kernel. It loads A/B/x, launches the kernel, collects tmp/y writes
// until every y word has been written, then streams the results back.
module gesummv_host #(
    parameter int N       = 8,
    parameter int LOGN    = 3,
    parameter int DW      = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [1:0]        load_sel,
    input  logic [2*LOGN-1:0] load_addr,
    input  logic [DW-1:0]     load_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              tstart,
    input  logic [2*LOGN-1:0] a_addr,
    input  logic              a_rd_en,
    output logic [DW-1:0]     a_rd_data,
    input  logic [2*LOGN-1:0] b_addr,
    input  logic              b_rd_en,
    output logic [DW-1:0]     b_rd_data,
    input  logic [LOGN-1:0]   x_addr,
    input  logic              x_rd_en,
    output logic [DW-1:0]     x_rd_data,
    input  logic [LOGN-1:0]   tmp_addr,
    input  logic              tmp_wr_en,
    input  logic [DW-1:0]     tmp_wr_data,
    input  logic [LOGN-1:0]   y_addr,
    input  logic              y_wr_en,
    input  logic [DW-1:0]     y_wr_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [LOGN-1:0]   res_idx,
    output logic [DW-1:0]     res_y,
    output logic [DW-1:0]     res_tmp
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, FIN} state_t;

    state_t          state;
    logic [DW-1:0]   a_mem   [N*N];
    logic [DW-1:0]   b_mem   [N*N];
    logic [DW-1:0]   x_mem   [N];
    logic [DW-1:0]   tmp_mem [N];
    logic [DW-1:0]   y_mem   [N];
    logic [N-1:0]    written;
    logic [CW-1:0]   cnt;
    logic [LOGN-1:0] idx;
    logic            load_fire;
    logic            in_run;

    assign load_ready = (state == IDLE);
    assign load_fire  = load_valid & load_ready;
    assign in_run     = (state == RUN);

    // Arrays have no reset so their contents survive rst.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            case (load_sel)
                2'd0:    a_mem[load_addr] <= load_data;
                2'd1:    b_mem[load_addr] <= load_data;
                2'd2:    x_mem[load_addr[LOGN-1:0]] <= load_data;
                default: ;
            endcase
        end
        if (in_run && tmp_wr_en) tmp_mem[tmp_addr] <= tmp_wr_data;
        if (in_run && y_wr_en)   y_mem[y_addr]     <= y_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rd_data <= '0;
            b_rd_data <= '0;
            x_rd_data <= '0;
        end else begin
            if (a_rd_en) a_rd_data <= a_mem[a_addr];
            if (b_rd_en) b_rd_data <= b_mem[b_addr];
            if (x_rd_en) x_rd_data <= x_mem[x_addr];
        end
    end

    // Arrays cannot change during DRAIN, so the result words stay stable while stalled.
    assign res_idx = idx;
    assign res_y   = y_mem[idx];
    assign res_tmp = tmp_mem[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tstart    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            idx       <= '0;
            written   <= '0;
            cnt       <= '0;
        end else begin
            tstart <= 1'b0;
            done   <= 1'b0;
            if (in_run && y_wr_en) written[y_addr] <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= START;
                        written <= '0;
                        err     <= 1'b0;
                        tstart  <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    // The bitmap is checked before this cycle's writes land, which gives the
                    // final tmp/y writes one cycle to commit before the drain starts.
                    if (&written) begin
                        state     <= DRAIN;
                        res_valid <= 1'b1;
                        idx       <= '0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (res_ready) begin
                        if (idx == LOGN'(N - 1)) begin
                            res_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= FIN;
                        end else begin
                            idx <= idx + LOGN'(1);
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
